// File: rtl/rs_lane_distributor_if.sv
// Group handshake bundle for rs_lane_distributor: codeword input side and lane output side.
// slave is the distributor's view; master is the upstream/downstream driver view.
interface rs_lane_distributor_if #(
    parameter int WIDTH_WORD_RS = 5440,
    parameter int NUM_LANES     = 16,
    parameter int SYMS_PER_BEAT = 8
);
    localparam int LANE_W = NUM_LANES * SYMS_PER_BEAT * 10;

    logic [WIDTH_WORD_RS-1:0] word_A;
    logic [WIDTH_WORD_RS-1:0] word_B;
    logic [WIDTH_WORD_RS-1:0] word_C;
    logic [WIDTH_WORD_RS-1:0] word_D;
    logic                     in_valid;
    logic                     in_ready;
    logic [LANE_W-1:0]        lane_data;
    logic                     out_valid;
    logic                     out_ready;
    logic                     out_sop;
    logic                     out_eop;

    modport master (
        output word_A, word_B, word_C, word_D, in_valid, out_ready,
        input  in_ready, lane_data, out_valid, out_sop, out_eop
    );

    modport slave (
        input  word_A, word_B, word_C, word_D, in_valid, out_ready,
        output in_ready, lane_data, out_valid, out_sop, out_eop
    );
endinterface

// File: rtl/rs_lane_distributor.sv
// Symbol-interleaves four RS codewords onto 16 lanes over BEATS beats; beat 0 valid the cycle after accept,
// back-to-back groups with no bubble; stalls hold data on !out_ready. RS_DIST_OVERRUN_DET_EN adds sticky overrun_err.
module rs_lane_distributor #(
    parameter int WIDTH_WORD_RS = 5440,
    parameter int NUM_LANES     = 16,
    parameter int SYMS_PER_BEAT = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    rs_lane_distributor_if.slave  bus
`ifdef RS_DIST_OVERRUN_DET_EN
    ,
    output logic                  overrun_err
`endif
);
    localparam int BEATS   = 136 / SYMS_PER_BEAT;
    localparam int BCW     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int SLICE_W = SYMS_PER_BEAT * 10;
    localparam int LANE_W  = NUM_LANES * SLICE_W;

    if (NUM_LANES != 16 || (136 % SYMS_PER_BEAT) != 0) begin : g_param_err
        $error("rs_lane_distributor: NUM_LANES must be 16 and SYMS_PER_BEAT must divide 136");
    end

    typedef enum logic {IDLE, SEND} state_t;

    state_t                         state_q, state_d;
    logic [BCW-1:0]                 bcnt_q, bcnt_d;
    logic [3:0][WIDTH_WORD_RS-1:0]  hold_q;
    logic                           load;
    logic                           last_beat;
    logic                           in_ready;
    logic                           out_valid;
    logic [BEATS-1:0][LANE_W-1:0]   beat_vec;

    assign last_beat = (bcnt_q == BCW'(BEATS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            bcnt_q  <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            if (load) begin
                hold_q <= {bus.word_D, bus.word_C, bus.word_B, bus.word_A};
            end
        end
    end

    // The last beat doubles as the accept slot for the next group, so in_ready
    // is the only output with a combinational dependency on out_ready.
    always_comb begin
        state_d   = state_q;
        bcnt_d    = bcnt_q;
        load      = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    load    = 1'b1;
                    bcnt_d  = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                out_valid = 1'b1;
                if (bus.out_ready) begin
                    if (last_beat) begin
                        in_ready = 1'b1;
                        bcnt_d   = '0;
                        if (bus.in_valid) begin
                            load = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        bcnt_d = bcnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Lane j, beat b, slot p carries codeword j%4, symbol 4*(b*SPB+p) + j/4; slot 0 sits in the MSBs.
    for (genvar b = 0; b < BEATS; b++) begin : g_beat
        for (genvar j = 0; j < NUM_LANES; j++) begin : g_lane
            for (genvar p = 0; p < SYMS_PER_BEAT; p++) begin : g_sym
                assign beat_vec[b][j*SLICE_W + (SYMS_PER_BEAT-1-p)*10 +: 10] =
                    hold_q[j%4][WIDTH_WORD_RS - 10 - 10*(4*(b*SYMS_PER_BEAT + p) + j/4) +: 10];
            end
        end
    end

    assign bus.lane_data = beat_vec[bcnt_q];
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_sop   = out_valid && (bcnt_q == '0);
    assign bus.out_eop   = out_valid && last_beat;

`ifdef RS_DIST_OVERRUN_DET_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_err <= 1'b0;
        end else if (bus.in_valid && !in_ready) begin
            overrun_err <= 1'b1;
        end
    end
`endif
endmodule
